// File: rtl/conv_encoder.sv
// ---------------------------------------------------------------------------
// conv_encoder
//
// Rate-1/2 feed-forward convolutional encoder. Takes one information bit per
// in_valid/in_ready handshake and emits its two coded bits serially (p0 then
// p1), one per clock, on out/valid_out. After a frame's last bit it can append
// K-1 zero tail bits so a downstream Viterbi decoder terminates in state 0.
//
// Parameters:
//   K        constraint length (3..9); the shift register holds K-1 bits
//   G0, G1   generator polynomials, K bits each, MSB taps the current input
//   TAIL_EN  1 = append K-1 zero tail bits after in_last, 0 = no tail
//
// Ports:
//   Clk        in   clock, rising edge
//   reset      in   synchronous, active-high; clears all state
//   in         in   information bit
//   in_valid   in   in is valid this cycle
//   in_last    in   accepted bit is the last of its frame
//   in_ready   out  encoder can accept a bit this cycle (from registers only)
//   out        out  coded bit (registered)
//   valid_out  out  out is valid (registered)
//   out_last   out  final coded bit of a frame (registered)
// ---------------------------------------------------------------------------
module conv_encoder #(
    parameter int           K       = 3,
    parameter logic [K-1:0] G0      = 3'b111,
    parameter logic [K-1:0] G1      = 3'b101,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic Clk,
    input  logic reset,
    input  logic in,
    input  logic in_valid,
    input  logic in_last,
    output logic in_ready,
    output logic out,
    output logic valid_out,
    output logic out_last
);

    localparam int            TW        = $clog2(K);
    localparam logic [TW-1:0] TAIL_LOAD = TW'(K - 1);

    // States are named after what is on the output this cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW0 = 2'd1,
        SHOW1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [K-2:0]    r_sr;
    logic [K-2:0]    w_sr_next;
    logic [TW-1:0]   r_tail_cnt;
    logic [TW-1:0]   w_tail_cnt_next;
    logic            r_p1;
    logic            w_p1_next;
    logic            r_bit_last;        // coded pair in flight is the frame's final one
    logic            w_bit_last_next;
    logic            r_out;
    logic            w_out_next;
    logic            r_valid_out;
    logic            w_valid_out_next;
    logic            r_out_last;
    logic            w_out_last_next;

    logic            w_accept;
    logic            w_tail_step;
    logic            w_bit;
    logic [K-1:0]    w_vec;
    logic            w_p0;
    logic            w_p1;

    // tail_cnt is loaded when the in_last bit is accepted, so it is already
    // non-zero through that bit's SHOW0/SHOW1; that alone keeps in_ready low
    // from the last data bit until the final tail SHOW1, without a separate
    // "tail pending" flag.
    assign in_ready = (r_state == IDLE) ||
                      ((r_state == SHOW1) && (r_tail_cnt == '0));

    assign w_accept    = in_valid && in_ready;
    assign w_tail_step = (r_state == SHOW1) && (r_tail_cnt != '0);

    // Bit being encoded: the accepted input, or a zero tail bit.
    assign w_bit = w_accept ? in : 1'b0;
    assign w_vec = {w_bit, r_sr};
    assign w_p0  = ^(w_vec & G0);
    assign w_p1  = ^(w_vec & G1);

    always_comb begin
        w_state_next     = r_state;
        w_sr_next        = r_sr;
        w_tail_cnt_next  = r_tail_cnt;
        w_p1_next        = r_p1;
        w_bit_last_next  = r_bit_last;
        w_out_next       = 1'b0;
        w_valid_out_next = 1'b0;
        w_out_last_next  = 1'b0;

        case (r_state)
            IDLE, SHOW1: begin
                if (w_accept || w_tail_step) begin
                    w_state_next     = SHOW0;
                    w_out_next       = w_p0;
                    w_valid_out_next = 1'b1;
                    w_p1_next        = w_p1;
                    // Newest bit enters at the top; sr[K-2] is the most recent.
                    w_sr_next        = {w_bit, r_sr[K-2:1]};
                    if (w_accept) begin
                        w_tail_cnt_next = (in_last && TAIL_EN) ? TAIL_LOAD : '0;
                        w_bit_last_next = in_last && !TAIL_EN;
                    end else begin
                        w_tail_cnt_next = r_tail_cnt - TW'(1);
                        w_bit_last_next = (r_tail_cnt == TW'(1));
                    end
                end else begin
                    w_state_next    = IDLE;
                    w_bit_last_next = 1'b0;
                end
            end
            SHOW0: begin
                w_state_next     = SHOW1;
                w_out_next       = r_p1;
                w_valid_out_next = 1'b1;
                w_out_last_next  = r_bit_last;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sr        <= '0;
            r_tail_cnt  <= '0;
            r_p1        <= 1'b0;
            r_bit_last  <= 1'b0;
            r_out       <= 1'b0;
            r_valid_out <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sr        <= w_sr_next;
            r_tail_cnt  <= w_tail_cnt_next;
            r_p1        <= w_p1_next;
            r_bit_last  <= w_bit_last_next;
            r_out       <= w_out_next;
            r_valid_out <= w_valid_out_next;
            r_out_last  <= w_out_last_next;
        end
    end

    assign out       = r_out;
    assign valid_out = r_valid_out;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_conv_encoder.sv
// ---------------------------------------------------------------------------
// tb_conv_encoder
//
// Three encoder instances share one input bus; sel chooses which one receives
// in_valid and whose outputs are monitored:
//   0: K=3, 7/5, tail on    1: K=3, 7/5, tail off    2: K=5, 23/35, tail on
// ---------------------------------------------------------------------------
module tb_conv_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       din_last = 1'b0;
    logic [1:0] sel = 2'd0;

    logic [2:0] iv_v;
    logic [2:0] rdy_v;
    logic [2:0] out_v;
    logic [2:0] vld_v;
    logic [2:0] last_v;

    assign iv_v[0] = din_valid && (sel == 2'd0);
    assign iv_v[1] = din_valid && (sel == 2'd1);
    assign iv_v[2] = din_valid && (sel == 2'd2);

    conv_encoder #(.K(3), .G0(3'b111), .G1(3'b101), .TAIL_EN(1'b1)) u_dut_tail (
        .Clk(clk), .reset(rst), .in(din), .in_valid(iv_v[0]), .in_last(din_last),
        .in_ready(rdy_v[0]), .out(out_v[0]), .valid_out(vld_v[0]), .out_last(last_v[0]));

    conv_encoder #(.K(3), .G0(3'b111), .G1(3'b101), .TAIL_EN(1'b0)) u_dut_notail (
        .Clk(clk), .reset(rst), .in(din), .in_valid(iv_v[1]), .in_last(din_last),
        .in_ready(rdy_v[1]), .out(out_v[1]), .valid_out(vld_v[1]), .out_last(last_v[1]));

    conv_encoder #(.K(5), .G0(5'b10011), .G1(5'b11101), .TAIL_EN(1'b1)) u_dut_k5 (
        .Clk(clk), .reset(rst), .in(din), .in_valid(iv_v[2]), .in_last(din_last),
        .in_ready(rdy_v[2]), .out(out_v[2]), .valid_out(vld_v[2]), .out_last(last_v[2]));

    logic m_rdy, m_out, m_vld, m_last;
    assign m_rdy  = rdy_v[sel];
    assign m_out  = out_v[sel];
    assign m_vld  = vld_v[sel];
    assign m_last = last_v[sel];

    // Output capture, sampled on the falling edge.
    int cyc = 0;
    bit cap_q[$];
    bit caplast_q[$];
    bit caprdy_q[$];
    int capcyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_vld) begin
            cap_q.push_back(m_out);
            caplast_q.push_back(m_last);
            caprdy_q.push_back(m_rdy);
            capcyc_q.push_back(cyc);
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic clear_cap();
        cap_q.delete();
        caplast_q.delete();
        caprdy_q.delete();
        capcyc_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        din_valid = 1'b0;
        din_last  = 1'b0;
        din       = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_cap();
    endtask

    // Present one bit and hold it until the selected encoder accepts it.
    task automatic send_bit(input bit b, input bit last, input bit gaps);
        int w;
        if (gaps) begin
            din_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        din       = b;
        din_last  = last;
        din_valid = 1'b1;
        w = 0;
        while (!m_rdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic drain();
        int idle;
        int w;
        idle = 0;
        w = 0;
        while (idle < 3 && w < 500) begin
            @(negedge clk);
            w++;
            idle = m_vld ? 0 : idle + 1;
        end
        if (w >= 500) check("drain_timeout", 0, 1);
    endtask

    task automatic check_stream(input string name, input bit e[$], input bit el[$],
                                input bit chk_contig);
        int n;
        int gaps;
        check({name, "_len"}, cap_q.size(), e.size());
        n = (cap_q.size() < e.size()) ? cap_q.size() : e.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_bit%0d(out,last)", name, i),
                  int'({cap_q[i], caplast_q[i]}), int'({e[i], el[i]}));
        if (chk_contig) begin
            gaps = 0;
            for (int i = 1; i < capcyc_q.size(); i++)
                if (capcyc_q[i] != capcyc_q[i-1] + 1) gaps++;
            check({name, "_gaps"}, gaps, 0);
        end
    endtask

    // Reference: textbook convolution y[n] = XOR_j g[K-1-j] & u[n-j] over the
    // (optionally zero-extended) message, two outputs per message bit.
    function automatic void ref_encode(input int k, input int g0, input int g1,
                                       input bit tail, input bit u[$], output bit y[$]);
        bit x[$];
        bit p0;
        bit p1;
        x = u;
        if (tail) for (int t = 0; t < k - 1; t++) x.push_back(1'b0);
        y.delete();
        for (int n = 0; n < x.size(); n++) begin
            p0 = 1'b0;
            p1 = 1'b0;
            for (int j = 0; j < k; j++) begin
                if (n - j >= 0) begin
                    p0 ^= g0[k-1-j] & x[n-j];
                    p1 ^= g1[k-1-j] & x[n-j];
                end
            end
            y.push_back(p0);
            y.push_back(p1);
        end
    endfunction

    typedef struct {
        logic [1:0]  sel;
        int          nbits;
        logic [7:0]  bits;      // MSB-first, low nbits used
        int          nexp;
        logic [15:0] exp;       // MSB-first, low nexp used
        int          last_pos;
    } vec_t;

    vec_t tbl[3];

    initial begin
        bit e[$];
        bit el[$];
        bit u[$];
        bit y[$];
        int acc;
        bit pend;
        int w;
        int nlast;

        tbl[0] = '{2'd0, 4, 8'b1011, 12, 16'b111000010111, 11};
        tbl[1] = '{2'd1, 4, 8'b1011, 8,  16'b11100001,     7};
        tbl[2] = '{2'd0, 1, 8'b1,    6,  16'b111011,       5};

        // Reset state of all three instances.
        do_reset();
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset_ready%0d", s), int'(rdy_v[s]), 1);
            check($sformatf("reset_outs%0d", s), int'({out_v[s], vld_v[s], last_v[s]}), 0);
        end

        // Table-driven frames with in_valid held high.
        for (int i = 0; i < 3; i++) begin
            sel = tbl[i].sel;
            do_reset();
            for (int j = 0; j < tbl[i].nbits; j++)
                send_bit(tbl[i].bits[tbl[i].nbits-1-j], j == tbl[i].nbits - 1, 1'b0);
            drain();
            e.delete();
            el.delete();
            for (int j = 0; j < tbl[i].nexp; j++) begin
                e.push_back(tbl[i].exp[tbl[i].nexp-1-j]);
                el.push_back(j == tbl[i].last_pos);
            end
            check_stream($sformatf("vec%0d", i), e, el, 1'b1);
            if (caprdy_q.size() > tbl[i].last_pos)
                check($sformatf("vec%0d_ready_at_last", i), int'(caprdy_q[tbl[i].last_pos]), 1);
        end

        // in_valid toggling every other cycle, bits 1,1, no last.
        sel = 2'd0;
        do_reset();
        acc  = 0;
        pend = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (pend) check($sformatf("toggle_show0_ready_c%0d", c), int'(m_rdy), 0);
            pend      = 1'b0;
            din       = 1'b1;
            din_last  = 1'b0;
            din_valid = (c % 2 == 0) && (acc < 2);
            if (din_valid && m_rdy) begin
                acc++;
                pend = 1'b1;
            end
        end
        din_valid = 1'b0;
        drain();
        check("toggle_accepts", acc, 2);
        e = '{1'b1, 1'b1, 1'b0, 1'b1};
        el = '{1'b0, 1'b0, 1'b0, 1'b0};
        check_stream("toggle", e, el, 1'b0);

        // Reset during the tail after 10 of 12 coded bits.
        sel = 2'd0;
        do_reset();
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        w = 0;
        while (cap_q.size() < 10 && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("abort_reached10", cap_q.size(), 10);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid_next", int'({m_vld, m_last}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", int'(m_rdy), 1);
        nlast = 0;
        foreach (caplast_q[i]) if (caplast_q[i]) nlast++;
        check("abort_no_out_last", nlast, 0);
        check("abort_len", cap_q.size(), 10);
        clear_cap();
        send_bit(1'b1, 1'b1, 1'b0);
        drain();
        e = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        el = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        check_stream("after_abort", e, el, 1'b1);

        // Two single-bit frames back-to-back.
        sel = 2'd0;
        do_reset();
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        drain();
        e.delete();
        el.delete();
        for (int f = 0; f < 2; f++) begin
            e.push_back(1'b1); e.push_back(1'b1);
            e.push_back(1'b1); e.push_back(1'b0);
            e.push_back(1'b1); e.push_back(1'b1);
            for (int p = 0; p < 6; p++) el.push_back(p == 5);
        end
        check_stream("b2b", e, el, 1'b1);
        for (int p = 0; p < caprdy_q.size() && p < 12; p++)
            check($sformatf("b2b_ready_pos%0d", p), int'(caprdy_q[p]), int'(p % 6 == 5));

        // Random frames against the reference model (gapped in_valid).
        for (int f = 0; f < 3; f++) begin
            sel = (f == 2) ? 2'd1 : 2'd2;
            if (f == 0 || f == 2) do_reset();
            clear_cap();
            u.delete();
            for (int j = 0; j < ((f == 2) ? 16 : 64); j++)
                u.push_back($urandom_range(0, 1) == 1);
            for (int j = 0; j < u.size(); j++)
                send_bit(u[j], j == u.size() - 1, 1'b1);
            drain();
            if (f == 2) ref_encode(3, 'b111, 'b101, 1'b0, u, y);
            else        ref_encode(5, 'b10011, 'b11101, 1'b1, u, y);
            el.delete();
            for (int j = 0; j < y.size(); j++) el.push_back(j == y.size() - 1);
            check_stream($sformatf("rand%0d", f), y, el, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
